// File: rtl/demux1to16_tdm.sv
// rtl/demux1to16_tdm.sv - TDM 1-to-16 serial demux with framed commit; optional parity stage under DEMUX_PARITY_EN
module demux1to16_tdm (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  input  logic        din_valid,
  input  logic        sof,
  output logic [0:15] out,
  output logic [0:3]  ch,
  output logic        busy,
  output logic        frame_done,
  output logic        err
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
`ifdef DEMUX_PARITY_EN
  localparam logic [1:0] S_PAR     = 2'd2;
`endif

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [0:15] shadow_q, shadow_d;
  logic [0:15] out_q, out_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  // Next-state: steer accepted bits into the shadow and decide commit/discard
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    out_d    = out_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    if (din_valid) begin
      case (state_q)
        S_IDLE: begin
          // Bits outside a frame are dropped without complaint
          if (sof) begin
            shadow_d[0] = din;
            cnt_d       = 4'd1;
            state_d     = S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (sof) begin
            // A new start marker abandons the partial frame
            err_d       = 1'b1;
            shadow_d[0] = din;
            cnt_d       = 4'd1;
          end else begin
            shadow_d[cnt_q] = din;
            if (cnt_q == 4'd15) begin
              cnt_d = 4'd0;
`ifdef DEMUX_PARITY_EN
              state_d = S_PAR;
`else
              out_d   = shadow_d;
              done_d  = 1'b1;
              state_d = S_IDLE;
`endif
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
`ifdef DEMUX_PARITY_EN
        S_PAR: begin
          if (sof) begin
            err_d       = 1'b1;
            shadow_d[0] = din;
            cnt_d       = 4'd1;
            state_d     = S_COLLECT;
          end else begin
            // Even parity: the extra bit must equal the XOR of all data bits
            if (din == (^shadow_q)) begin
              out_d  = shadow_q;
              done_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            cnt_d   = 4'd0;
            state_d = S_IDLE;
          end
        end
`endif
        default: begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // State registers; reset clears everything including the committed frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      shadow_q <= 16'b0;
      out_q    <= 16'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      out_q    <= out_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign out        = out_q;
  assign ch         = cnt_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = done_q;
  assign err        = err_q;

endmodule
